// File: rtl/ni_flit_packetizer_if.sv
// Handshake bundle between the packetizer, its upstream addr+data FIFO
// and the local router input port.
interface ni_flit_packetizer_if #(
  parameter int FLIT_W = 34
);
  logic              fifo_empty;
  logic [63:0]       fifo_data;
  logic              fifo_rd_en;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic              flit_ready;

  // The packetizer pops the FIFO and drives flits toward the router.
  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  flit_ready,
    output fifo_rd_en,
    output flit_out,
    output flit_valid
  );

  // The surrounding FIFO and router.
  modport slave (
    output fifo_empty,
    output fifo_data,
    output flit_ready,
    input  fifo_rd_en,
    input  flit_out,
    input  flit_valid
  );
endinterface

// File: rtl/ni_flit_packetizer.sv
// Network-interface egress packetizer: pops one {addr, data} FIFO entry at a
// time and sends it to the router as a HEAD flit (address) followed by a
// TAIL flit (data), with a saturating count of completed packets.
module ni_flit_packetizer #(
  parameter int FLIT_W     = 34,
  parameter int COORD_W    = 4,
  parameter int DEST_X_LSB = 24,
  parameter int DEST_Y_LSB = 28,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  ni_flit_packetizer_if.master bus,
  output logic [COORD_W-1:0]   dest_x,
  output logic [COORD_W-1:0]   dest_y,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_count
);

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HEAD,
    ST_TAIL
  } state_t;

  state_t              state_reg, state_next;
  logic                rd_en_reg, rd_en_next;
  logic [FLIT_W-1:0]   flit_reg, flit_next;
  logic                valid_reg, valid_next;
  logic [31:0]         data_reg, data_next;
  logic [COORD_W-1:0]  dest_x_reg, dest_x_next;
  logic [COORD_W-1:0]  dest_y_reg, dest_y_next;
  logic [CNT_W-1:0]    count_reg, count_next;

  // State and all registered outputs; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      rd_en_reg  <= 1'b0;
      flit_reg   <= '0;
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      dest_x_reg <= '0;
      dest_y_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rd_en_reg  <= rd_en_next;
      flit_reg   <= flit_next;
      valid_reg  <= valid_next;
      data_reg   <= data_next;
      dest_x_reg <= dest_x_next;
      dest_y_reg <= dest_y_next;
      count_reg  <= count_next;
    end
  end

  // Next-state and next-output logic; read enable is a single-cycle pulse,
  // everything else holds unless a transition updates it.
  always_comb begin
    state_next  = state_reg;
    rd_en_next  = 1'b0;
    flit_next   = flit_reg;
    valid_next  = valid_reg;
    data_next   = data_reg;
    dest_x_next = dest_x_reg;
    dest_y_next = dest_y_reg;
    count_next  = count_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (!bus.fifo_empty) begin
          rd_en_next = 1'b1;
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // FIFO output is valid now; capture the entry and present HEAD.
        data_next   = bus.fifo_data[31:0];
        dest_x_next = bus.fifo_data[32+DEST_X_LSB +: COORD_W];
        dest_y_next = bus.fifo_data[32+DEST_Y_LSB +: COORD_W];
        flit_next   = {FLIT_HEAD, bus.fifo_data[63:32]};
        valid_next  = 1'b1;
        state_next  = ST_HEAD;
      end

      ST_HEAD: begin
        if (bus.flit_ready) begin
          flit_next  = {FLIT_TAIL, data_reg};
          state_next = ST_TAIL;
        end
      end

      ST_TAIL: begin
        if (bus.flit_ready) begin
          valid_next = 1'b0;
          if (count_reg != '1) begin
            count_next = count_reg + CNT_W'(1);
          end
          // Chain straight into the next fetch to keep 3 cycles per packet.
          if (!bus.fifo_empty) begin
            rd_en_next = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.fifo_rd_en = rd_en_reg;
  assign bus.flit_out   = flit_reg;
  assign bus.flit_valid = valid_reg;
  assign dest_x         = dest_x_reg;
  assign dest_y         = dest_y_reg;
  assign busy           = (state_reg != ST_IDLE);
  assign pkt_count      = count_reg;

endmodule

// File: tb/tb_ni_flit_packetizer.sv
// Self-checking bench: table of FIFO entries with their expected HEAD/TAIL
// flits and coordinates, a FIFO model and router monitor per DUT, and a
// scoreboard queue of expected flits filled whenever an entry is queued.
module tb_ni_flit_packetizer;

  typedef struct {
    logic [63:0] entry;
    logic [33:0] head;
    logic [33:0] tail;
    logic [3:0]  x;
    logic [3:0]  y;
  } vec_t;

  typedef struct {
    logic [33:0] flit;
    logic [3:0]  x;
    logic [3:0]  y;
  } exp_t;

  logic clk;
  logic reset;

  ni_flit_packetizer_if #(.FLIT_W(34)) bus_a ();
  ni_flit_packetizer_if #(.FLIT_W(34)) bus_b ();

  logic [3:0]  dx_a, dy_a, dx_b, dy_b;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  ni_flit_packetizer u_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a),
    .dest_x    (dx_a),
    .dest_y    (dy_a),
    .busy      (busy_a),
    .pkt_count (cnt_a)
  );

  ni_flit_packetizer #(.CNT_W(2)) u_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b),
    .dest_x    (dx_b),
    .dest_y    (dy_b),
    .busy      (busy_b),
    .pkt_count (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  vec_t        vecs [5];
  logic [63:0] fifo_q_a [$];
  logic [63:0] fifo_q_b [$];
  exp_t        exp_q_a [$];
  exp_t        exp_q_b [$];
  int          head_hs_a = 0, tail_hs_a = 0, flits_b = 0, rd_cnt_a = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int i);
    exp_t e;
    fifo_q_a.push_back(vecs[i].entry);
    e.x = vecs[i].x; e.y = vecs[i].y;
    e.flit = vecs[i].head; exp_q_a.push_back(e);
    e.flit = vecs[i].tail; exp_q_a.push_back(e);
  endtask

  task automatic push_b(input int i);
    exp_t e;
    fifo_q_b.push_back(vecs[i].entry);
    e.x = vecs[i].x; e.y = vecs[i].y;
    e.flit = vecs[i].head; exp_q_b.push_back(e);
    e.flit = vecs[i].tail; exp_q_b.push_back(e);
  endtask

  // FIFO models: pop on an edge where read enable was high.
  always @(posedge clk) begin
    if (bus_a.fifo_rd_en && fifo_q_a.size() > 0) void'(fifo_q_a.pop_front());
    if (bus_b.fifo_rd_en && fifo_q_b.size() > 0) void'(fifo_q_b.pop_front());
    if (bus_a.fifo_rd_en) rd_cnt_a++;
  end

  // FIFO outputs refreshed mid-cycle; read enable must never see an empty FIFO.
  always @(negedge clk) begin
    bus_a.fifo_empty = (fifo_q_a.size() == 0);
    bus_a.fifo_data  = (fifo_q_a.size() > 0) ? fifo_q_a[0] : 64'h0;
    bus_b.fifo_empty = (fifo_q_b.size() == 0);
    bus_b.fifo_data  = (fifo_q_b.size() > 0) ? fifo_q_b[0] : 64'h0;
    if (!reset && bus_a.fifo_rd_en) check("rd_en_while_empty_a", bus_a.fifo_empty, 0);
  end

  // Router monitor A: every valid cycle must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus_a.flit_valid) begin
      if (exp_q_a.size() == 0) begin
        checks++;
        $display("FAIL unexpected_flit_a: got 0x%0h, required no flit", bus_a.flit_out);
      end else begin
        check("flit_a", {30'h0, bus_a.flit_out}, {30'h0, exp_q_a[0].flit});
        check("dest_x_a", dx_a, exp_q_a[0].x);
        check("dest_y_a", dy_a, exp_q_a[0].y);
        if (bus_a.flit_ready) begin
          $display("A handshake flit 0x%09h", bus_a.flit_out);
          if (exp_q_a[0].flit[33:32] == 2'b11) tail_hs_a++;
          else head_hs_a++;
          void'(exp_q_a.pop_front());
        end
      end
    end
  end

  // Router monitor B (saturating counter instance).
  always @(negedge clk) begin
    if (!reset && bus_b.flit_valid) begin
      if (exp_q_b.size() == 0) begin
        checks++;
        $display("FAIL unexpected_flit_b: got 0x%0h, required no flit", bus_b.flit_out);
      end else if (bus_b.flit_ready) begin
        $display("B handshake flit 0x%09h", bus_b.flit_out);
        check("flit_b", {30'h0, bus_b.flit_out}, {30'h0, exp_q_b[0].flit});
        flits_b++;
        void'(exp_q_b.pop_front());
      end
    end
  end

  initial begin
    int exp_pkt;
    int h0, t0, r0;
    vecs[0] = '{64'h1200_0040_DEAD_BEEF, 34'h1_1200_0040, 34'h3_DEAD_BEEF, 4'h2, 4'h1};
    vecs[1] = '{64'h3A00_0100_0000_0001, 34'h1_3A00_0100, 34'h3_0000_0001, 4'hA, 4'h3};
    vecs[2] = '{64'hF500_FFFF_FFFF_FFFF, 34'h1_F500_FFFF, 34'h3_FFFF_FFFF, 4'h5, 4'hF};
    vecs[3] = '{64'h0000_0000_1234_5678, 34'h1_0000_0000, 34'h3_1234_5678, 4'h0, 4'h0};
    vecs[4] = '{64'h6C00_0004_A5A5_5A5A, 34'h1_6C00_0004, 34'h3_A5A5_5A5A, 4'hC, 4'h6};

    reset = 1'b1;
    bus_a.flit_ready = 1'b1;
    bus_b.flit_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("reset_rd_en", bus_a.fifo_rd_en, 0);
    check("reset_valid", bus_a.flit_valid, 0);
    check("reset_flit", bus_a.flit_out, 0);
    check("reset_dest", {dx_a, dy_a}, 0);
    check("reset_busy", busy_a, 0);
    check("reset_count", cnt_a, 0);
    reset = 1'b0;
    tick();
    exp_pkt = 0;

    // Single packets from the table, ready held high
    for (int i = 0; i < 5; i++) begin
      push_a(i);
      tick();
      check("single_rd_en", bus_a.fifo_rd_en, 1);
      check("single_busy", busy_a, 1);
      check("single_fetch_valid", bus_a.flit_valid, 0);
      tick();
      check("single_head_valid", bus_a.flit_valid, 1);
      check("single_head", bus_a.flit_out, vecs[i].head);
      check("single_dest_x", dx_a, vecs[i].x);
      check("single_dest_y", dy_a, vecs[i].y);
      check("single_rd_low", bus_a.fifo_rd_en, 0);
      tick();
      check("single_tail", bus_a.flit_out, vecs[i].tail);
      tick();
      exp_pkt++;
      check("single_done_valid", bus_a.flit_valid, 0);
      check("single_done_busy", busy_a, 0);
      check("single_count", cnt_a, exp_pkt);
      check("single_dest_kept", {dy_a, dx_a}, {vecs[i].y, vecs[i].x});
    end

    // Backpressure: 5-cycle HEAD stall, 3-cycle TAIL stall
    h0 = head_hs_a; t0 = tail_hs_a;
    bus_a.flit_ready = 1'b0;
    push_a(0);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_head_hold", bus_a.flit_out, vecs[0].head);
    end
    bus_a.flit_ready = 1'b1;
    tick();
    bus_a.flit_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_tail_hold", bus_a.flit_out, vecs[0].tail);
      check("bp_tail_valid", bus_a.flit_valid, 1);
    end
    bus_a.flit_ready = 1'b1;
    tick();
    exp_pkt++;
    check("bp_count", cnt_a, exp_pkt);
    check("bp_head_hs", head_hs_a - h0, 1);
    check("bp_tail_hs", tail_hs_a - t0, 1);

    // Back-to-back: 4 entries, 3 cycles per packet
    r0 = rd_cnt_a;
    for (int i = 0; i < 4; i++) push_a(i);
    for (int c = 1; c <= 13; c++) begin
      tick();
      check("b2b_rd_en", bus_a.fifo_rd_en, (c == 1 || c == 4 || c == 7 || c == 10));
      check("b2b_valid", bus_a.flit_valid, (c % 3 != 1) && (c < 13));
    end
    exp_pkt += 4;
    check("b2b_count", cnt_a, exp_pkt);
    check("b2b_rd_pulses", rd_cnt_a - r0, 4);
    check("b2b_idle", busy_a, 0);
    check("b2b_scoreboard_empty", exp_q_a.size(), 0);

    // Empty FIFO for 20 cycles
    for (int c = 0; c < 20; c++) begin
      tick();
      check("empty_quiet", {bus_a.fifo_rd_en, bus_a.flit_valid, busy_a}, 0);
    end

    // Reset during HEAD stall
    bus_a.flit_ready = 1'b0;
    push_a(1);
    repeat (4) tick();
    check("rst_pre_valid", bus_a.flit_valid, 1);
    reset = 1'b1;
    tick();
    check("rst_valid", bus_a.flit_valid, 0);
    check("rst_count", cnt_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_dest", {dx_a, dy_a}, 0);
    exp_q_a.delete();
    reset = 1'b0;
    tick();
    bus_a.flit_ready = 1'b1;
    h0 = head_hs_a; t0 = tail_hs_a;
    push_a(4);
    repeat (4) tick();
    check("rst_after_count", cnt_a, 1);
    check("rst_after_hs", (head_hs_a - h0) + (tail_hs_a - t0), 2);
    check("rst_after_idle", busy_a, 0);

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) push_b(i);
    tick();
    for (int k = 1; k <= 5; k++) begin
      repeat (3) tick();
      check("sat_count", cnt_b, (k > 3) ? 3 : k);
    end
    check("sat_flits", flits_b, 10);
    check("sat_idle", busy_b, 0);
    check("sat_scoreboard_empty", exp_q_b.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
